// File: rtl/board_checker_if.sv
// board_checker_if: start/board request and result bundle for board_checker.
interface board_checker_if;
    logic         i_start;
    logic [323:0] i_board;
    logic         o_busy;
    logic         o_done;
    logic         o_complete;
    logic         o_conflict;
    logic [4:0]   o_conflict_unit;
    logic [3:0]   o_conflict_i;
    logic [3:0]   o_conflict_j;
    logic [6:0]   o_empty_count;
    modport master (
        output i_start, i_board,
        input  o_busy, o_done, o_complete, o_conflict,
        input  o_conflict_unit, o_conflict_i, o_conflict_j, o_empty_count
    );
    modport slave (
        input  i_start, i_board,
        output o_busy, o_done, o_complete, o_conflict,
        output o_conflict_unit, o_conflict_i, o_conflict_j, o_empty_count
    );
endinterface

// File: rtl/board_checker.sv
// board_checker: snapshots the 9x9 board and walks all 27 units one cell per clock,
// reporting the first rule conflict, the empty-cell count and a win flag.
module board_checker #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input logic           clk,
    input logic           reset,
    board_checker_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   r_state;
    logic [323:0] r_snap;
    logic [4:0]   r_u;
    logic [3:0]   r_p;
    logic [8:0]   r_seen;
    logic         r_conflict;
    logic         r_valid;
    logic [4:0]   r_unit;
    logic [3:0]   r_ci;
    logic [3:0]   r_cj;
    logic [6:0]   r_empty;

    logic [4:0]   w_b;
    logic [3:0]   w_i;
    logic [3:0]   w_j;
    logic [6:0]   w_k;
    logic [3:0]   w_v;
    logic [8:0]   w_hot;
    logic         w_bad;
    logic         w_last;
    logic         w_exit;

    // Map (unit, position) to board coordinates: rows, then columns, then 3x3 boxes.
    always_comb begin
        w_b    = r_u - 5'd18;
        w_i    = (r_u < 5'd9) ? r_u[3:0] : (r_u < 5'd18) ? r_p : 4'(3 * (w_b / 3) + r_p / 3);
        w_j    = (r_u < 5'd9) ? r_p : (r_u < 5'd18) ? 4'(r_u - 5'd9) : 4'(3 * (w_b % 3) + r_p % 3);
        w_k    = 7'(w_i * 9 + w_j);
        w_v    = r_snap[{w_k, 2'b00} +: 4];
        w_hot  = (w_v >= 4'd1 && w_v <= 4'd9) ? 9'(9'd1 << (w_v - 4'd1)) : 9'd0;
        w_bad  = (w_v > 4'd9) | (|(w_hot & r_seen));
        w_last = (r_u == 5'd26) && (r_p == 4'd8);
        w_exit = w_last | (EARLY_EXIT & w_bad & ~r_conflict);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_snap     <= '0;
            r_u        <= '0;
            r_p        <= '0;
            r_seen     <= '0;
            r_conflict <= 1'b0;
            r_valid    <= 1'b0;
            r_unit     <= '0;
            r_ci       <= '0;
            r_cj       <= '0;
            r_empty    <= '0;
        end else if (r_state == S_IDLE) begin
            if (bus.i_start) begin
                r_state    <= S_SCAN;
                r_snap     <= bus.i_board;
                r_u        <= '0;
                r_p        <= '0;
                r_seen     <= '0;
                r_conflict <= 1'b0;
                r_valid    <= 1'b0;
                r_unit     <= '0;
                r_ci       <= '0;
                r_cj       <= '0;
                r_empty    <= '0;
            end
        end else if (r_state == S_SCAN) begin
            // Rows cover every cell exactly once, so empties are only counted there.
            if (w_v == 4'd0 && r_u < 5'd9)
                r_empty <= r_empty + 7'd1;
            if (w_bad && !r_conflict) begin
                r_conflict <= 1'b1;
                r_unit     <= r_u;
                r_ci       <= w_i;
                r_cj       <= w_j;
            end
            r_seen <= (r_p == 4'd8) ? 9'd0 : (r_seen | w_hot);
            r_p    <= (r_p == 4'd8) ? 4'd0 : r_p + 4'd1;
            r_u    <= (r_p == 4'd8) ? r_u + 5'd1 : r_u;
            if (w_exit) begin
                r_state <= S_DONE;
                r_valid <= 1'b1;
            end
        end else begin
            r_state <= S_IDLE;
        end
    end

    assign bus.o_busy          = (r_state == S_SCAN);
    assign bus.o_done          = (r_state == S_DONE);
    assign bus.o_complete      = r_valid & ~r_conflict & (r_empty == 7'd0);
    assign bus.o_conflict      = r_conflict;
    assign bus.o_conflict_unit = r_unit;
    assign bus.o_conflict_i    = r_ci;
    assign bus.o_conflict_j    = r_cj;
    assign bus.o_empty_count   = r_empty;
endmodule

// File: tb/tb_board_checker.sv
// tb_board_checker: directed checks of board_checker, full-scan and early-exit builds.
module tb_board_checker;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start0 = 1'b0;
    logic         start1 = 1'b0;
    logic [323:0] board = '0;
    bit           sel = 1'b0;
    int           checks = 0;
    int           errors = 0;

    board_checker_if bif0();
    board_checker_if bif1();
    assign bif0.i_start = start0;
    assign bif0.i_board = board;
    assign bif1.i_start = start1;
    assign bif1.i_board = board;

    board_checker #(.EARLY_EXIT(1'b0)) u_full  (.clk(clk), .reset(reset), .bus(bif0.slave));
    board_checker #(.EARLY_EXIT(1'b1)) u_early (.clk(clk), .reset(reset), .bus(bif1.slave));

    logic       busy, done, complete, conflict;
    logic [4:0] cunit;
    logic [3:0] ci, cj;
    logic [6:0] empty;
    assign busy     = sel ? bif1.o_busy          : bif0.o_busy;
    assign done     = sel ? bif1.o_done          : bif0.o_done;
    assign complete = sel ? bif1.o_complete      : bif0.o_complete;
    assign conflict = sel ? bif1.o_conflict      : bif0.o_conflict;
    assign cunit    = sel ? bif1.o_conflict_unit : bif0.o_conflict_unit;
    assign ci       = sel ? bif1.o_conflict_i    : bif0.o_conflict_i;
    assign cj       = sel ? bif1.o_conflict_j    : bif0.o_conflict_j;
    assign empty    = sel ? bif1.o_empty_count   : bif0.o_empty_count;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        tick;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic run(output int lat, output int nb);
        pulse;
        lat = -1;
        nb  = 0;
        for (int n = 0; n < 400; n++) begin
            if (busy) nb++;
            if (done) begin
                lat = n;
                break;
            end
            tick;
        end
    endtask

    task automatic results(input string t, input int e_conf, input int e_unit, input int e_i,
                           input int e_j, input int e_empty, input int e_comp);
        check({t, ".conflict"}, 32'(conflict), e_conf);
        check({t, ".unit"},     32'(cunit),    e_unit);
        check({t, ".i"},        32'(ci),       e_i);
        check({t, ".j"},        32'(cj),       e_j);
        check({t, ".empty"},    32'(empty),    e_empty);
        check({t, ".complete"}, 32'(complete), e_comp);
    endtask

    function automatic logic [323:0] solved();
        logic [323:0] b;
        b = '0;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 9; j++)
                b[4*(i*9+j) +: 4] = 4'(((i * 3 + i / 3 + j) % 9) + 1);
        return b;
    endfunction

    function automatic logic [323:0] put(input logic [323:0] b, input int i, input int j, input logic [3:0] v);
        logic [323:0] r;
        r = b;
        r[4*(i*9+j) +: 4] = v;
        return r;
    endfunction

    int lat, nb, cnt, first;

    initial begin
        tick;
        tick;
        check("rst.busy", 32'(busy), 0);
        check("rst.done", 32'(done), 0);
        results("rst", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick;

        board = solved();
        run(lat, nb);
        check("solved.latency", lat, 243);
        check("solved.busy_cycles", nb, 243);
        results("solved", 0, 0, 0, 0, 0, 1);
        tick;
        check("solved.done_pulse", 32'(done), 0);
        check("solved.hold_complete", 32'(complete), 1);

        board = '0;
        run(lat, nb);
        check("zero.latency", lat, 243);
        results("zero", 0, 0, 0, 0, 81, 0);
        tick;

        board = put(solved(), 0, 3, 4'd1);
        run(lat, nb);
        check("row.latency", lat, 243);
        results("row", 1, 0, 0, 3, 0, 0);
        tick;

        board = put(put('0, 0, 0, 4'd7), 1, 1, 4'd7);
        run(lat, nb);
        results("box", 1, 18, 1, 1, 79, 0);
        tick;

        board = put('0, 2, 2, 4'd12);
        run(lat, nb);
        check("inv.latency", lat, 243);
        results("inv", 1, 2, 2, 2, 80, 0);
        tick;

        sel = 1'b1;
        board = put(put('0, 0, 0, 4'd5), 0, 3, 4'd5);
        run(lat, nb);
        check("early.latency", lat, 4);
        check("early.busy_cycles", nb, 4);
        results("early", 1, 0, 0, 3, 2, 0);
        tick;
        board = put('0, 2, 2, 4'd12);
        run(lat, nb);
        check("early_inv.latency", lat, 21);
        results("early_inv", 1, 2, 2, 2, 20, 0);
        tick;
        sel = 1'b0;

        board = put(solved(), 0, 3, 4'd1);
        pulse;
        for (int n = 0; n < 99; n++) tick;
        check("abort.busy_before", 32'(busy), 1);
        reset = 1'b0;
        tick;
        check("abort.busy", 32'(busy), 0);
        check("abort.done", 32'(done), 0);
        results("abort", 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        cnt = 0;
        for (int n = 0; n < 300; n++) begin
            if (done) cnt++;
            tick;
        end
        check("abort.no_done", cnt, 0);

        board = solved();
        pulse;
        cnt = 0;
        first = -1;
        for (int n = 0; n < 400; n++) begin
            if (done) begin
                cnt++;
                if (first < 0) first = n;
            end
            start0 = (n == 50);
            tick;
        end
        start0 = 1'b0;
        check("repulse.done_count", cnt, 1);
        check("repulse.latency", first, 243);
        check("repulse.complete", 32'(complete), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
